// File: rtl/result_uart_tx_if.sv
// ============================================================================
// Module      : result_uart_tx_if
// Description : Result handshake between the CNN top level and the UART
//               result transmitter: a 5-bit class index with a one-cycle
//               valid qualifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_uart_tx_if;
    logic [4:0] i_result_data;
    logic       i_result_data_valid;

    modport master (
        output i_result_data,
        output i_result_data_valid
    );

    modport slave (
        input i_result_data,
        input i_result_data_valid
    );
endinterface

`default_nettype wire

// File: rtl/result_uart_tx.sv
// ============================================================================
// Module      : result_uart_tx
// Description : Buffers CNN classification results in a small FIFO and sends
//               each one to the host as a UART byte {3'b000, result}, LSB
//               first, 8N1. Define RESULT_PARITY_EN to add an even-parity
//               bit (8E1, 11-bit frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_uart_tx #(
    parameter int CLK_FREQ   = 200000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                en,
    result_uart_tx_if.slave    res_if,
    output logic               o_uart_tx,
    output logic               o_busy,
    output logic               o_fifo_full,
    output logic               o_overflow,
    output logic [15:0]        o_tx_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;

    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  C_FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RESULT_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [4:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] occ_q;
    logic             overflow_q;

    // Transmitter state
    state_t           state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic [15:0]      tx_count_q;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;
    logic baud_last;

    assign fifo_full  = (occ_q == C_FIFO_FULL);
    assign fifo_empty = (occ_q == '0);
    // A frame launches only from IDLE while enabled; the pop frees a slot on
    // the same edge, so a push into a full FIFO is still accepted then.
    assign pop        = (state_q == S_IDLE) && en && !fifo_empty;
    assign push       = en && res_if.i_result_data_valid && (!fifo_full || pop);
    assign drop       = en && res_if.i_result_data_valid && fifo_full && !pop;
    assign baud_last  = (baud_q == C_BAUD_LAST);

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      occ_q <= occ_q + CNT_W'(1);
            else if (pop && !push) occ_q <= occ_q - CNT_W'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    // FIFO data array; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= res_if.i_result_data;
    end

    // Frame sequencer; the line register follows the state one cycle later,
    // so every bit still lasts exactly CLKS_PER_BIT cycles on the wire
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            tx_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (pop) begin
                        shift_q <= {3'b000, mem_q[rd_ptr_q]};
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    tx_q <= shift_q[bit_q];
                    if (baud_last) begin
                        baud_q <= '0;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef RESULT_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`ifdef RESULT_PARITY_EN
                S_PARITY: begin
                    tx_q <= ^shift_q;
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud_q     <= '0;
                        tx_count_q <= tx_count_q + 16'd1;
                        state_q    <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_uart_tx   = tx_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_fifo_full = fifo_full;
    assign o_overflow  = overflow_q;
    assign o_tx_count  = tx_count_q;

endmodule

`default_nettype wire

// File: tb/tb_result_uart_tx.sv
// ============================================================================
// Module      : tb_result_uart_tx
// Description : Directed self-checking bench for result_uart_tx at
//               CLKS_PER_BIT = 16, FIFO_DEPTH = 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_uart_tx;

    localparam int CPB = 16;
`ifdef RESULT_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Start-to-start distance of back-to-back frames: one frame plus one IDLE cycle
    localparam int FRAME_GAP = NBITS * CPB + 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        o_uart_tx;
    logic        o_busy;
    logic        o_fifo_full;
    logic        o_overflow;
    logic [15:0] o_tx_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    result_uart_tx_if res_if ();

    result_uart_tx #(
        .CLK_FREQ   (1600),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .res_if      (res_if),
        .o_uart_tx   (o_uart_tx),
        .o_busy      (o_busy),
        .o_fifo_full (o_fifo_full),
        .o_overflow  (o_overflow),
        .o_tx_count  (o_tx_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [4:0] d);
        res_if.i_result_data       = d;
        res_if.i_result_data_valid = 1'b1;
        tick(1);
        res_if.i_result_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    // Wait (bounded) for the start-bit falling edge; returns its cycle stamp
    task automatic wait_start(output int fall);
        for (int k = 0; k < 400 && o_uart_tx !== 1'b0; k++) tick(1);
        check("start_bit_seen", o_uart_tx, 0);
        fall = cyc;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && o_busy !== 1'b0; k++) tick(1);
        check("idle_reached", o_busy, 0);
    endtask

    // Entered in the first cycle of a start bit; samples the middle of every
    // line bit. With drop set, en is pulled low for 10 cycles mid-DATA while
    // a result is offered.
    task automatic check_frame(input logic [7:0] d, input bit drop);
        logic [NBITS-1:0] line;
        line          = '1;
        line[0]       = 1'b0;
        line[8:1]     = d;
`ifdef RESULT_PARITY_EN
        line[9]       = ^d;
`endif
        tick(CPB / 2);
        check($sformatf("frame%0h_start", d), o_uart_tx, line[0]);
        for (int i = 1; i < NBITS; i++) begin
            if (drop && i == 3) begin
                en                         = 1'b0;
                res_if.i_result_data       = 5'd4;
                res_if.i_result_data_valid = 1'b1;
                tick(10);
                en                         = 1'b1;
                res_if.i_result_data_valid = 1'b0;
                tick(CPB - 10);
            end else begin
                tick(CPB);
            end
            check($sformatf("frame%0h_bit%0d", d, i), o_uart_tx, line[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int f0, f1, f2;
        int falls;

        res_if.i_result_data       = 5'd0;
        res_if.i_result_data_valid = 1'b0;
        en    = 1'b1;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Reset then idle
        tick(200);
        check("rst_tx",       o_uart_tx,   1);
        check("rst_busy",     o_busy,      0);
        check("rst_count",    o_tx_count,  0);
        check("rst_full",     o_fifo_full, 0);
        check("rst_overflow", o_overflow,  0);

        // Single result 7: latency and line shape
        push(5'd7);
        check("lat_e0_tx",   o_uart_tx, 1);
        check("lat_e0_busy", o_busy,    0);
        tick(1);
        check("lat_e1_tx",   o_uart_tx, 1);
        check("lat_e1_busy", o_busy,    1);
        tick(1);
        check("lat_e2_tx",   o_uart_tx, 0);
        wait_start(f0);
        check_frame(8'h07, 1'b0);
        tick(CPB / 2 - 2);
        check("single_count_pre", o_tx_count, 0);
        check("single_busy_pre",  o_busy,     1);
        tick(1);
        check("single_count", o_tx_count, 1);
        check("single_busy",  o_busy,     0);

        // Three back-to-back results
        do_reset();
        push(5'd1);
        push(5'd2);
        push(5'd3);
        wait_start(f0);
        check_frame(8'h01, 1'b0);
        wait_start(f1);
        check_frame(8'h02, 1'b0);
        wait_start(f2);
        check_frame(8'h03, 1'b0);
        check("b2b_gap1", f1 - f0, FRAME_GAP);
        check("b2b_gap2", f2 - f1, FRAME_GAP);
        tick(20);
        check("b2b_count", o_tx_count, 3);
        check("b2b_busy",  o_busy,     0);

        // Fill the FIFO during a frame, overflow, then push on a full-FIFO pop
        do_reset();
        push(5'd10);
        tick(10);
        push(5'd11);
        push(5'd12);
        push(5'd13);
        push(5'd14);
        check("fill_full",      o_fifo_full, 1);
        check("fill_overflow0", o_overflow,  0);
        push(5'd15);
        check("fill_overflow1", o_overflow,  1);
        check("fill_full2",     o_fifo_full, 1);
        wait_idle();
        push(5'd16);
        check("fullpop_full",     o_fifo_full, 1);
        check("fullpop_overflow", o_overflow,  1);
        wait_start(f0);
        check_frame(8'h0b, 1'b0);
        wait_start(f0);
        check_frame(8'h0c, 1'b0);
        wait_start(f0);
        check_frame(8'h0d, 1'b0);
        wait_start(f0);
        check_frame(8'h0e, 1'b0);
        wait_start(f0);
        check_frame(8'h10, 1'b0);
        tick(20);
        check("fill_count",     o_tx_count,  6);
        check("fill_overflow2", o_overflow,  1);
        check("fill_empty",     o_fifo_full, 0);

        // en dropped mid-DATA while a result is offered
        do_reset();
        push(5'd9);
        wait_start(f0);
        check_frame(8'h09, 1'b1);
        tick(20);
        check("en_count",    o_tx_count, 1);
        check("en_overflow", o_overflow, 0);
        falls = 0;
        repeat (200) begin
            tick(1);
            if (o_uart_tx !== 1'b1) falls++;
        end
        check("en_no_frame",  falls,      0);
        check("en_count_end", o_tx_count, 1);

        // Reset mid-frame with two entries queued
        do_reset();
        push(5'd20);
        push(5'd21);
        push(5'd22);
        tick(3);
        check("midrst_pre_tx", o_uart_tx, 0);
        rst_n = 1'b0;
        tick(1);
        check("midrst_tx",    o_uart_tx,   1);
        check("midrst_busy",  o_busy,      0);
        check("midrst_count", o_tx_count,  0);
        check("midrst_full",  o_fifo_full, 0);
        rst_n = 1'b1;
        falls = 0;
        repeat (300) begin
            tick(1);
            if (o_uart_tx !== 1'b1) falls++;
        end
        check("midrst_no_frame", falls,      0);
        check("midrst_count2",   o_tx_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
